// File: rtl/ghost_mode_controller.sv
// ghost_mode_controller: per-tick mode timing and serialised direction choice for NUM_GHOSTS ghosts
module ghost_mode_controller #(
    parameter int NUM_GHOSTS    = 4,
    parameter int X_W           = 11,
    parameter int Y_W           = 10,
    parameter int X_MAX         = 639,
    parameter int Y_MAX         = 479,
    parameter int SCATTER_TICKS = 420,
    parameter int CHASE_TICKS   = 1200,
    parameter int FRIGHT_TICKS  = 360
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      tick,
    input  logic                      power_pellet,
    input  logic [X_W-1:0]            pacman_pos_x,
    input  logic [Y_W-1:0]            pacman_pos_y,
    input  logic [NUM_GHOSTS*X_W-1:0] ghost_pos_x,
    input  logic [NUM_GHOSTS*Y_W-1:0] ghost_pos_y,
    input  logic [NUM_GHOSTS*4-1:0]   valid_moves,
    output logic [NUM_GHOSTS*4-1:0]   move_direction,
    output logic [1:0]                mode,
    output logic                      round_done,
    output logic                      busy,
    output logic                      tick_overrun
);
    localparam int IDX_W = NUM_GHOSTS > 1 ? $clog2(NUM_GHOSTS) : 1;
    localparam int T_M1  = SCATTER_TICKS > CHASE_TICKS ? SCATTER_TICKS : CHASE_TICKS;
    localparam int T_MAX = T_M1 > FRIGHT_TICKS ? T_M1 : FRIGHT_TICKS;
    localparam int T_W   = $clog2(T_MAX + 1);
    localparam int D_W   = X_W > Y_W ? X_W : Y_W;
    localparam logic [3:0] RIGHT = 4'b0001, UP = 4'b0010, DOWN = 4'b0100, LEFT = 4'b1000;

    typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;
    typedef enum logic [1:0] {SCATTER = 2'b00, CHASE = 2'b01, FRIGHT = 2'b10} mode_t;

    function automatic logic [3:0] rev(input logic [3:0] d);
        return {d[0], d[1], d[2], d[3]};
    endfunction

    state_t                    state_q, state_d;
    mode_t                     mode_q, mode_d, saved_mode_q, saved_mode_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [T_W-1:0]            timer_q, timer_d, saved_timer_q, saved_timer_d;
    logic                      pellet_q, pellet_d, rev_round_q, rev_round_d, overrun_q, overrun_d;
    logic [X_W-1:0]            px_q, px_d;
    logic [Y_W-1:0]            py_q, py_d;
    logic [NUM_GHOSTS*X_W-1:0] gx_q, gx_d;
    logic [NUM_GHOSTS*Y_W-1:0] gy_q, gy_d;
    logic [NUM_GHOSTS*4-1:0]   vm_q, vm_d, prev_q, prev_d, shadow_q, shadow_d, dir_q, dir_d;

    logic [X_W-1:0] gx, tx, dx;
    logic [Y_W-1:0] gy, ty, dy;
    logic [1:0]     corner;
    logic [3:0]     vm, prev, rp, cand, tow, pref, pref_x, pref_y, prio, dir;

    // Shared per-ghost datapath, fed by the ghost selected by idx_q
    always_comb begin
        gx     = gx_q[int'(idx_q)*X_W +: X_W];
        gy     = gy_q[int'(idx_q)*Y_W +: Y_W];
        vm     = vm_q[int'(idx_q)*4 +: 4];
        prev   = prev_q[int'(idx_q)*4 +: 4];
        corner = 2'(idx_q);
        tx     = mode_q == SCATTER ? (corner[0] ? X_W'(X_MAX) : '0) : px_q;
        ty     = mode_q == SCATTER ? (corner[1] ? Y_W'(Y_MAX) : '0) : py_q;
        dx     = tx > gx ? tx - gx : gx - tx;
        dy     = ty > gy ? ty - gy : gy - ty;
        tow    = (tx > gx ? RIGHT : tx < gx ? LEFT : 4'b0000) | (ty > gy ? DOWN : ty < gy ? UP : 4'b0000);
        rp     = rev(prev);
        cand   = vm & ~rp;
        pref   = cand & (mode_q == FRIGHT ? rev(tow) : tow);
        pref_x = pref & (RIGHT | LEFT);
        pref_y = pref & (UP | DOWN);
        prio   = cand[1] ? UP : cand[2] ? DOWN : cand[0] ? RIGHT : cand[3] ? LEFT : 4'b0000;
        dir    = rev_round_q && |(rp & vm) ? rp :
                 cand == 4'b0000 ? rp & vm :
                 |pref_x && |pref_y ? (D_W'(dx) > D_W'(dy) ? pref_x : pref_y) :
                 |pref ? pref : prio;
    end

    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        saved_mode_d  = saved_mode_q;
        idx_d         = idx_q;
        timer_d       = timer_q;
        saved_timer_d = saved_timer_q;
        pellet_d      = pellet_q | power_pellet;
        rev_round_d   = rev_round_q;
        overrun_d     = overrun_q | (tick && state_q != IDLE);
        px_d          = px_q;
        py_d          = py_q;
        gx_d          = gx_q;
        gy_d          = gy_q;
        vm_d          = vm_q;
        prev_d        = prev_q;
        shadow_d      = shadow_q;
        dir_d         = dir_q;
        if (state_q == IDLE && tick) begin
            px_d     = pacman_pos_x;
            py_d     = pacman_pos_y;
            gx_d     = ghost_pos_x;
            gy_d     = ghost_pos_y;
            vm_d     = valid_moves;
            state_d  = EVAL;
            idx_d    = '0;
            pellet_d = power_pellet;
            if (pellet_q) begin
                if (mode_q != FRIGHT) begin
                    saved_mode_d  = mode_q;
                    saved_timer_d = timer_q;
                    mode_d        = FRIGHT;
                    rev_round_d   = 1'b1;
                end
                timer_d = T_W'(FRIGHT_TICKS);
            end else if (timer_q == T_W'(1)) begin
                mode_d  = mode_q == SCATTER ? CHASE : mode_q == CHASE ? SCATTER : saved_mode_q;
                timer_d = mode_q == SCATTER ? T_W'(CHASE_TICKS) :
                          mode_q == CHASE ? T_W'(SCATTER_TICKS) : saved_timer_q;
            end else begin
                timer_d = timer_q - 1'b1;
            end
        end
        if (state_q == EVAL) begin
            shadow_d[int'(idx_q)*4 +: 4] = dir;
            idx_d = idx_q + 1'b1;
            if (idx_q == IDX_W'(NUM_GHOSTS - 1)) begin
                state_d = DONE;
                dir_d   = shadow_d;
                prev_d  = shadow_d;
            end
        end
        if (state_q == DONE) begin
            state_d     = IDLE;
            rev_round_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            mode_q        <= SCATTER;
            saved_mode_q  <= SCATTER;
            idx_q         <= '0;
            timer_q       <= T_W'(SCATTER_TICKS);
            saved_timer_q <= '0;
            pellet_q      <= 1'b0;
            rev_round_q   <= 1'b0;
            overrun_q     <= 1'b0;
            px_q          <= '0;
            py_q          <= '0;
            gx_q          <= '0;
            gy_q          <= '0;
            vm_q          <= '0;
            prev_q        <= '0;
            shadow_q      <= '0;
            dir_q         <= '0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            saved_mode_q  <= saved_mode_d;
            idx_q         <= idx_d;
            timer_q       <= timer_d;
            saved_timer_q <= saved_timer_d;
            pellet_q      <= pellet_d;
            rev_round_q   <= rev_round_d;
            overrun_q     <= overrun_d;
            px_q          <= px_d;
            py_q          <= py_d;
            gx_q          <= gx_d;
            gy_q          <= gy_d;
            vm_q          <= vm_d;
            prev_q        <= prev_d;
            shadow_q      <= shadow_d;
            dir_q         <= dir_d;
        end
    end

    assign move_direction = dir_q;
    assign mode           = mode_q;
    assign round_done     = state_q == DONE;
    assign busy           = state_q != IDLE;
    assign tick_overrun   = overrun_q;
endmodule

// File: tb/tb_ghost_mode_controller.sv
// tb_ghost_mode_controller: table-driven rounds with a round_done scoreboard plus overrun/reset sequences
module tb_ghost_mode_controller;
    localparam int NG = 4;
    localparam int XW = 11;
    localparam int YW = 10;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic tick = 1'b0;
    logic power_pellet = 1'b0;
    logic [XW-1:0]    pacman_pos_x = '0;
    logic [YW-1:0]    pacman_pos_y = '0;
    logic [NG*XW-1:0] ghost_pos_x = '0;
    logic [NG*YW-1:0] ghost_pos_y = '0;
    logic [NG*4-1:0]  valid_moves = '0;
    logic [NG*4-1:0]  move_direction;
    logic [1:0]       mode;
    logic             round_done, busy, tick_overrun;

    always #5 clk = ~clk;

    ghost_mode_controller #(
        .NUM_GHOSTS(NG), .X_W(XW), .Y_W(YW), .X_MAX(639), .Y_MAX(479),
        .SCATTER_TICKS(3), .CHASE_TICKS(2), .FRIGHT_TICKS(2)
    ) dut (
        .clk(clk), .reset(reset), .tick(tick), .power_pellet(power_pellet),
        .pacman_pos_x(pacman_pos_x), .pacman_pos_y(pacman_pos_y),
        .ghost_pos_x(ghost_pos_x), .ghost_pos_y(ghost_pos_y), .valid_moves(valid_moves),
        .move_direction(move_direction), .mode(mode), .round_done(round_done),
        .busy(busy), .tick_overrun(tick_overrun)
    );

    typedef struct {
        logic [XW-1:0]    px;
        logic [YW-1:0]    py;
        logic [NG*XW-1:0] gx;
        logic [NG*YW-1:0] gy;
        logic [NG*4-1:0]  vm;
        logic             pel;
        logic [1:0]       md;
        logic [NG*4-1:0]  dir;
    } vec_t;

    vec_t vt[14];
    logic [NG*4+1:0] exp_q[$];
    logic [NG*4+1:0] e;
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [NG*XW-1:0] gxs(input int a, input int b, input int c, input int d);
        return {XW'(d), XW'(c), XW'(b), XW'(a)};
    endfunction

    function automatic logic [NG*YW-1:0] gys(input int a, input int b, input int c, input int d);
        return {YW'(d), YW'(c), YW'(b), YW'(a)};
    endfunction

    function automatic vec_t mk(input int px, input int py, input logic [NG*XW-1:0] gx,
                                input logic [NG*YW-1:0] gy, input logic [15:0] vm, input logic pel,
                                input logic [1:0] md, input logic [15:0] dir);
        vec_t v;
        v.px = XW'(px);
        v.py = YW'(py);
        v.gx = gx;
        v.gy = gy;
        v.vm = vm;
        v.pel = pel;
        v.md = md;
        v.dir = dir;
        return v;
    endfunction

    always @(negedge clk) begin
        if (round_done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_round_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("move_direction", int'(move_direction), int'(e[NG*4-1:0]));
                check("mode", int'(mode), int'(e[NG*4+1:NG*4]));
            end
        end
    end

    task automatic do_round(input vec_t v, input bit dbl);
        int lat;
        int bcnt;
        pacman_pos_x = v.px;
        pacman_pos_y = v.py;
        ghost_pos_x = v.gx;
        ghost_pos_y = v.gy;
        valid_moves = v.vm;
        if (v.pel) begin
            power_pellet = 1'b1;
            @(negedge clk);
            power_pellet = 1'b0;
            @(negedge clk);
        end
        exp_q.push_back({v.md, v.dir});
        tick = 1'b1;
        @(negedge clk);
        tick = dbl;
        lat = 1;
        bcnt = 0;
        while (!round_done && lat < 50) begin
            bcnt += int'(busy);
            @(negedge clk);
            tick = 1'b0;
            lat++;
        end
        bcnt += int'(busy);
        check("latency", lat, NG + 1);
        check("busy_cycles", bcnt, NG + 1);
        @(negedge clk);
        check("busy_after", int'(busy), 0);
    endtask

    localparam logic [3:0] R = 4'b0001, U = 4'b0010, D = 4'b0100, L = 4'b1000, Z = 4'b0000, A = 4'b1111;

    initial begin
        vt[0]  = mk(0, 0, gxs(100, 100, 100, 100), gys(100, 100, 100, 100), {A, A, A, A}, 1'b0, 2'b00, {R, D, R, U});
        vt[1]  = mk(0, 0, gxs(300, 100, 100, 100), gys(50, 100, 100, 100), {Z, Z, Z, 4'b0111}, 1'b0, 2'b00, {Z, Z, Z, U});
        vt[2]  = mk(300, 150, gxs(100, 100, 100, 100), gys(100, 100, 100, 100), {Z, Z, A, Z}, 1'b0, 2'b01, {Z, Z, R, Z});
        vt[3]  = mk(120, 400, gxs(100, 200, 100, 20), gys(100, 400, 100, 300), {A, A, 4'b1001, Z}, 1'b0, 2'b01, {D, D, R, Z});
        vt[4]  = mk(0, 0, gxs(100, 100, 100, 100), gys(100, 100, 100, 100), {Z, Z, L, Z}, 1'b0, 2'b00, {Z, Z, L, Z});
        vt[5]  = mk(0, 0, gxs(100, 100, 100, 100), gys(100, 100, 100, 100), {Z, Z, Z, U}, 1'b0, 2'b00, {Z, Z, Z, U});
        vt[6]  = mk(300, 150, gxs(100, 100, 100, 100), gys(100, 100, 100, 100), {Z, Z, A, A}, 1'b1, 2'b10, {Z, Z, L, D});
        vt[7]  = mk(300, 150, gxs(100, 290, 100, 100), gys(100, 400, 100, 100), {Z, Z, A, A}, 1'b0, 2'b10, {Z, Z, D, L});
        vt[8]  = mk(0, 0, gxs(100, 100, 100, 100), gys(100, 100, 100, 100), {Z, Z, Z, Z}, 1'b0, 2'b00, {Z, Z, Z, Z});
        vt[9]  = mk(0, 0, gxs(100, 100, 0, 100), gys(100, 100, 479, 100), {Z, A, Z, Z}, 1'b0, 2'b00, {Z, U, Z, Z});
        vt[10] = mk(150, 150, gxs(100, 100, 100, 100), gys(100, 100, 100, 100), {Z, Z, Z, A}, 1'b0, 2'b01, {Z, Z, Z, D});
        vt[11] = mk(150, 150, gxs(100, 100, 100, 100), gys(100, 100, 100, 100), {Z, Z, Z, A}, 1'b0, 2'b01, {Z, Z, Z, D});
        vt[12] = mk(0, 0, gxs(100, 100, 100, 100), gys(100, 100, 100, 100), {Z, Z, Z, A}, 1'b0, 2'b00, {Z, Z, Z, L});
        vt[13] = mk(0, 0, gxs(100, 100, 100, 100), gys(100, 100, 100, 100), {Z, Z, Z, A}, 1'b0, 2'b00, {Z, Z, Z, U});

        repeat (3) @(negedge clk);
        check("reset_move_direction", int'(move_direction), 0);
        check("reset_mode", int'(mode), 0);
        check("reset_round_done", int'(round_done), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_tick_overrun", int'(tick_overrun), 0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 11; i++) do_round(vt[i], 1'b0);
        check("overrun_clear", int'(tick_overrun), 0);
        do_round(vt[11], 1'b1);
        check("overrun_set", int'(tick_overrun), 1);
        do_round(vt[12], 1'b0);
        check("overrun_sticky", int'(tick_overrun), 1);

        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_move_direction", int'(move_direction), 0);
        check("abort_mode", int'(mode), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_round_done", int'(round_done), 0);
        check("abort_tick_overrun", int'(tick_overrun), 0);
        repeat (NG + 4) @(negedge clk);

        do_round(vt[13], 1'b0);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ghost_mode_controller.md
Name: ghost_mode_controller

Overview:
Parametrised multi-ghost steering engine; successor to the single-ghost chase logic. Each movement tick it decides one direction for each of NUM_GHOSTS ghosts. It serialises all ghosts through one shared distance and decision datapath, one ghost per cycle. It adds global SCATTER/CHASE/FRIGHTENED modes with tick-based timers, forced reversal on power-pellet entry, and internally held previous directions. It sits between the per-ghost valid-move detectors and the ghost position updaters.

Parameters:
NUM_GHOSTS, 4, ghosts served per round (1..8)
X_W, 11, x coordinate width
Y_W, 10, y coordinate width
X_MAX, 639, scatter-corner x for right corners
Y_MAX, 479, scatter-corner y for bottom corners
SCATTER_TICKS, 420, ticks per SCATTER phase
CHASE_TICKS, 1200, ticks per CHASE phase
FRIGHT_TICKS, 360, ticks per FRIGHTENED phase

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
tick  in  1  one-cycle movement strobe (clk domain)
power_pellet  in  1  one-cycle pulse: pacman ate a pellet
pacman_pos_x  in  X_W  pacman x
pacman_pos_y  in  Y_W  pacman y
ghost_pos_x  in  NUM_GHOSTS*X_W  packed; ghost i at [i*X_W +: X_W]
ghost_pos_y  in  NUM_GHOSTS*Y_W  packed
valid_moves  in  NUM_GHOSTS*4  packed per-ghost valid-move masks
move_direction  out  NUM_GHOSTS*4  packed one-hot directions; 0 = stopped
mode  out  2  00 SCATTER, 01 CHASE, 10 FRIGHTENED
round_done  out  1  one-cycle pulse: move_direction updated
busy  out  1  high while a round is evaluating
tick_overrun  out  1  sticky: a tick arrived while busy

Behaviour:
- Direction encoding: RIGHT=0001, UP=0010, DOWN=0100, LEFT=1000. reverse(): RIGHT<->LEFT, UP<->DOWN, 0->0.
- Reset outputs: move_direction=0, mode=SCATTER, round_done=0, busy=0, tick_overrun=0.
- Reset internal state: timer=SCATTER_TICKS, prev_dir[i]=0, pellet_pending=0, reverse_round=0, FSM=IDLE.
- A reset asserted mid-round aborts the round; no round_done follows.
- power_pellet is latched into pellet_pending on any cycle. It is cleared when consumed at an accepted tick.
- FSM IDLE -> EVAL -> DONE -> IDLE.
- IDLE, tick=1 (accepted):
  - Snapshot all positions and valid_moves.
  - Run the mode update, then go to EVAL with idx=0.
- Mode update, pellet_pending=1:
  - If mode is not FRIGHTENED: save mode and remaining timer, set mode=FRIGHTENED, timer=FRIGHT_TICKS, reverse_round=1.
  - If already FRIGHTENED: reload timer=FRIGHT_TICKS only; no reversal.
- Mode update, pellet_pending=0:
  - If timer==1: switch mode. SCATTER->CHASE (CHASE_TICKS); CHASE->SCATTER (SCATTER_TICKS); FRIGHTENED->saved mode with saved timer.
  - Otherwise decrement timer.
- EVAL: evaluates ghost idx each cycle, writes a shadow direction register, then idx++. After idx==NUM_GHOSTS-1 go to DONE.
- DONE (1 cycle): copy shadow to move_direction and prev_dir, pulse round_done, clear reverse_round.
- Latency: tick accepted at cycle T -> round_done and new move_direction at T+NUM_GHOSTS+1. busy=1 from T+1 through T+NUM_GHOSTS+1.
- A tick while busy is dropped and sets tick_overrun. The mode timer does not advance for dropped ticks.
- Target per ghost:
  - CHASE: pacman position.
  - SCATTER: corner k=i mod 4. k=0 (0,0); 1 (X_MAX,0); 2 (0,Y_MAX); 3 (X_MAX,Y_MAX).
  - FRIGHTENED: pacman position, with "toward" inverted to "away".
- Distances are unsigned absolute differences: dx is X_W wide, dy is Y_W wide; no wrap.
- toward_x = RIGHT if tx>gx, LEFT if tx<gx, 0 if equal. toward_y = DOWN if ty>gy, UP if ty<gy, 0 if equal.
- FRIGHTENED uses reverse() of each toward term; a zero term stays 0.
- Decision rule for a ghost:
  - cand = valid & ~reverse(prev_dir).
  - pref = cand & (toward_x|toward_y).
  - If pref has two bits: pick the axis with larger distance; on a tie pick vertical.
  - If pref has one bit: pick it.
  - If pref has no bits: pick the first present in cand by priority UP, DOWN, RIGHT, LEFT.
  - If cand is empty: pick reverse(prev_dir) if valid, else 0.
- Reversal round (reverse_round=1): each ghost with prev_dir!=0 whose reverse(prev_dir) is valid outputs reverse(prev_dir). All other ghosts use the normal rule.

Test Plan:
- Reset, then one tick with NUM_GHOSTS=2: round_done exactly 3 cycles after tick; mode=00; busy high for 3 cycles.
- CHASE, ghost (100,100), pacman (300,150), valid=1111, prev=0 -> RIGHT (dx=200 > dy=50). Pacman (120,400) -> DOWN. Pacman (150,150) (tie) -> DOWN.
- prev=RIGHT, valid=1001, pacman to the left -> RIGHT. LEFT is the reverse direction and is excluded, and the fallback picks RIGHT.
- SCATTER_TICKS=3, CHASE_TICKS=2: ticks 1-2 SCATTER, tick 3 CHASE, tick 5 SCATTER; mode output matches each round.
- Pellet with prev_dir=UP, DOWN valid -> next round outputs DOWN for that ghost, mode=10. FRIGHT_TICKS=2 -> returns to the saved mode and saved remaining timer.
- Second tick 1 cycle after an accepted tick -> tick_overrun=1 and remains set; round count and timer unaffected. reset mid-EVAL -> no round_done, outputs return to reset values.
